// File: rtl/tone_meter.sv
// tone_meter: measures the period (in accepted samples) between consecutive
// rising hysteresis crossings of an audio stream, together with the peak
// magnitude seen over that period. A run that never completes a period within
// MAX_PERIOD samples raises a one-cycle timeout and restarts the search.
// Optional build macro TONE_METER_OFFSET_BIN_EN: din is offset binary
// (16'h8000 = zero) instead of two's complement.
module tone_meter #(
  parameter logic [15:0] HYST       = 16'd256,
  parameter logic [15:0] MAX_PERIOD = 16'd65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic [15:0] period,
  output logic [15:0] peak,
  output logic        meas_valid,
  output logic        timeout
);

  typedef enum logic [1:0] {
    SEEK_LOW  = 2'd0,
    SEEK_HIGH = 2'd1,
    RUN_LOW   = 2'd2,
    RUN_HIGH  = 2'd3
  } state_t;

  // Thresholds widened to 17 bits so -HYST and every 16-bit sample compare
  // without overflow.
  localparam logic signed [16:0] HYST_POS = {1'b0, HYST};
  localparam logic signed [16:0] HYST_NEG = -HYST_POS;

  // Magnitude of a signed 16-bit sample as an unsigned 16-bit value;
  // -32768 maps to 32768 with no saturation.
  function automatic logic [15:0] abs_mag(input logic signed [15:0] x);
    logic [15:0] ux;
    ux = x;
    abs_mag = x[15] ? (~ux + 16'd1) : ux;
  endfunction

  state_t             state_q, state_d;
  logic        [15:0] cnt_q, cnt_d;
  logic        [15:0] acc_q, acc_d;
  logic        [15:0] period_q, period_d;
  logic        [15:0] peak_q, peak_d;
  logic               meas_q, meas_d;
  logic               tmo_q, tmo_d;

  logic signed [15:0] samp;
  logic signed [16:0] samp17;
  logic        [15:0] mag;
  logic        [15:0] cnt_inc;
  logic        [15:0] acc_max;
  logic               lt_neg;
  logic               ge_pos;

  // Sample conditioning: optional offset-binary conversion, magnitude and
  // hysteresis comparisons.
  always_comb begin
`ifdef TONE_METER_OFFSET_BIN_EN
    samp = {~din[15], din[14:0]};
`else
    samp = din;
`endif
    samp17  = {samp[15], samp};
    mag     = abs_mag(samp);
    lt_neg  = (samp17 < HYST_NEG);
    ge_pos  = (samp17 >= HYST_POS);
    cnt_inc = cnt_q + 16'd1;
    acc_max = (mag > acc_q) ? mag : acc_q;
  end

  // Next-state logic: crossing detection, counting, peak tracking, timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    period_d = period_q;
    peak_d   = peak_q;
    meas_d   = 1'b0;
    tmo_d    = 1'b0;
    if (din_valid) begin
      case (state_q)
        SEEK_LOW: begin
          if (lt_neg) state_d = SEEK_HIGH;
        end
        SEEK_HIGH: begin
          // First rising crossing: start a fresh period.
          if (ge_pos) begin
            state_d = RUN_LOW;
            cnt_d   = 16'd1;
            acc_d   = mag;
          end
        end
        RUN_LOW, RUN_HIGH: begin
          if ((state_q == RUN_HIGH) && ge_pos) begin
            // Measured crossing; takes priority over a coincident timeout.
            state_d  = RUN_LOW;
            period_d = cnt_q;
            peak_d   = acc_q;
            meas_d   = 1'b1;
            cnt_d    = 16'd1;
            acc_d    = mag;
          end else if (cnt_inc == MAX_PERIOD) begin
            state_d = SEEK_LOW;
            tmo_d   = 1'b1;
            cnt_d   = 16'd0;
            acc_d   = 16'd0;
          end else begin
            cnt_d = cnt_inc;
            acc_d = acc_max;
            if ((state_q == RUN_LOW) && lt_neg) state_d = RUN_HIGH;
          end
        end
        default: state_d = SEEK_LOW;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= SEEK_LOW;
      cnt_q    <= 16'd0;
      acc_q    <= 16'd0;
      period_q <= 16'd0;
      peak_q   <= 16'd0;
      meas_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      period_q <= period_d;
      peak_q   <= peak_d;
      meas_q   <= meas_d;
      tmo_q    <= tmo_d;
    end
  end

  assign period     = period_q;
  assign peak       = peak_q;
  assign meas_valid = meas_q;
  assign timeout    = tmo_q;

endmodule
